// File: rtl/ppe_rr_grant_pipe_pkg.sv
// rtl/ppe_rr_grant_pipe_pkg.sv - shared widths, types and rotate helper for the grant pipe
package ppe_rr_grant_pipe_pkg;

   localparam int N_REQ = 512;
   localparam int IDX_W = 9;

   typedef logic [N_REQ-1:0] req_t;
   typedef logic [IDX_W-1:0] idx_t;

   // Rotate right so that bit sh of v lands at bit 0; sh=0 leaves v untouched.
   function automatic req_t rotate_right(input req_t v, input idx_t sh);
      return (v >> sh) | (v << (N_REQ - int'(sh)));
   endfunction

endpackage

// File: rtl/ppe_rr_grant_pipe_if.sv
// rtl/ppe_rr_grant_pipe_if.sv - request/grant handshake bundle for the grant pipe
interface ppe_rr_grant_pipe_if;
   import ppe_rr_grant_pipe_pkg::*;

   logic in_valid;
   logic in_ready;
   req_t in_req;
   idx_t in_prio;
   logic rr_mode;
   logic out_valid;
   logic out_ready;
   logic out_found;
   idx_t out_idx;

   modport slave (
      input  in_valid, in_req, in_prio, rr_mode, out_ready,
      output in_ready, out_valid, out_found, out_idx
   );

   modport master (
      output in_valid, in_req, in_prio, rr_mode, out_ready,
      input  in_ready, out_valid, out_found, out_idx
   );

endinterface

// File: rtl/encoder_512_to_9.sv
// rtl/encoder_512_to_9.sv - lowest-index priority encoder, 512 requests to a 9-bit index
module encoder_512_to_9 (
   input  logic [511:0] req,
   output logic [8:0]   idx
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = 511; i >= 0; i--) begin
         if (req[i]) begin
            idx = 9'(i);
         end
      end
   end

endmodule

// File: rtl/ppe_rr_grant_pipe.sv
// rtl/ppe_rr_grant_pipe.sv - three-stage programmable-priority / round-robin grant pipeline
module ppe_rr_grant_pipe
   import ppe_rr_grant_pipe_pkg::*;
#(
   parameter idx_t RR_RST_PTR = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   ppe_rr_grant_pipe_if.slave bus
);

   logic adv;
   logic accept;
   idx_t sel_ptr;
   idx_t rr_ptr;

   logic s1_v;
   req_t s1_rot;
   idx_t s1_ptr;

   logic s2_v;
   idx_t s2_e;
   logic s2_f;
   idx_t s2_ptr;

   logic out_valid_q;
   logic out_found_q;
   idx_t out_idx_q;

   idx_t enc_idx;

   // Whole pipe moves as one; a held output freezes every stage behind it.
   assign adv          = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && adv;
   assign sel_ptr      = bus.rr_mode ? rr_ptr : bus.in_prio;
   assign bus.in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_rot <= '0;
         s1_ptr <= '0;
      end else if (adv) begin
         s1_v <= bus.in_valid;
         if (accept) begin
            s1_rot <= rotate_right(bus.in_req, sel_ptr);
            s1_ptr <= sel_ptr;
         end
      end
   end

   encoder_512_to_9 u_enc (
      .req (s1_rot),
      .idx (enc_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v   <= 1'b0;
         s2_e   <= '0;
         s2_f   <= 1'b0;
         s2_ptr <= '0;
      end else if (adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_e   <= enc_idx;
            s2_f   <= |s1_rot;
            s2_ptr <= s1_ptr;
         end
      end
   end

   // The encoded index is relative to the rotated frame; adding ptr undoes the rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_found_q <= 1'b0;
         out_idx_q   <= '0;
      end else if (adv) begin
         out_valid_q <= s2_v;
         if (s2_v) begin
            out_found_q <= s2_f;
            out_idx_q   <= s2_f ? idx_t'(s2_e + s2_ptr) : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= RR_RST_PTR;
      end else if (out_valid_q && bus.out_ready && out_found_q) begin
         rr_ptr <= idx_t'(out_idx_q + idx_t'(1));
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_found = out_found_q;
   assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_ppe_rr_grant_pipe.sv
// tb/tb_ppe_rr_grant_pipe.sv - randomized and directed bench for the grant pipeline
module tb_ppe_rr_grant_pipe;
   import ppe_rr_grant_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ppe_rr_grant_pipe_if bus ();

   ppe_rr_grant_pipe #(.RR_RST_PTR(9'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit f;
      int idx;
   } exp_t;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   int   rr_model = 0;
   int   hs_cnt = 0;
   int   last_idx = 0;
   bit   last_found = 0;
   bit   held = 0;
   bit   held_f = 0;
   idx_t held_idx = '0;

   // Grant = first set request found walking upward from ptr, wrapping at 512.
   function automatic exp_t ref_grant(input req_t req, input int ptr);
      exp_t r;
      r.f = 0;
      r.idx = 0;
      for (int k = 0; k < N_REQ; k++) begin
         int j;
         j = (ptr + k) % N_REQ;
         if (req[j]) begin
            r.f = 1;
            r.idx = j;
            return r;
         end
      end
      return r;
   endfunction

   function automatic req_t gen_req();
      req_t r;
      r = '0;
      case ($urandom % 5)
         0: r = '0;
         1: r = '1;
         2: r[$urandom % N_REQ] = 1'b1;
         3: for (int i = 0; i < 3; i++) r[$urandom % N_REQ] = 1'b1;
         default: for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      int p;
      if (!rst_n) begin
         held = 0;
      end else begin
         if (held) begin
            n_checks++;
            if (bus.out_valid === 1'b1 && bus.out_idx === held_idx && bus.out_found === held_f) n_pass++;
            else $display("FAIL hold_stable: valid=%0b idx=%0d found=%0b required valid=1 idx=%0d found=%0b",
                          bus.out_valid, bus.out_idx, bus.out_found, held_idx, held_f);
         end
         n_checks++;
         if (bus.in_ready === (!bus.out_valid || bus.out_ready)) n_pass++;
         else $display("FAIL in_ready: got=%0b required=%0b", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (bus.in_valid && bus.in_ready) begin
            p = bus.rr_mode ? rr_model : int'(bus.in_prio);
            exp_q.push_back(ref_grant(bus.in_req, p));
         end
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_output: idx=%0d found=%0b required no output", bus.out_idx, bus.out_found);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_found === e.f && bus.out_idx === idx_t'(e.idx)) n_pass++;
               else $display("FAIL scoreboard: idx=%0d found=%0b required idx=%0d found=%0b",
                             bus.out_idx, bus.out_found, e.idx, e.f);
               if (e.f) rr_model = (e.idx + 1) % N_REQ;
            end
            hs_cnt++;
            last_idx = int'(bus.out_idx);
            last_found = bus.out_found;
         end
         held = bus.out_valid && !bus.out_ready;
         held_idx = bus.out_idx;
         held_f = bus.out_found;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.rr_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid === 1'b0 && bus.out_found === 1'b0 && bus.out_idx === 9'd0) n_pass++;
      else $display("FAIL reset_outputs: valid=%0b found=%0b idx=%0d required 0/0/0",
                    bus.out_valid, bus.out_found, bus.out_idx);
      exp_q.delete();
      rr_model = 0;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready === 1'b1) n_pass++;
      else $display("FAIL reset_in_ready: got=%0b required=1", bus.in_ready);
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      req_t t_req[10];
      int   t_prio[10];
      bit   t_f[10];
      int   t_idx[10];
      req_t r5_300;
      int   cyc;
      r5_300 = '0;
      r5_300[5] = 1'b1;
      r5_300[300] = 1'b1;
      for (int i = 0; i < 4; i++) t_req[i] = r5_300;
      t_prio[0] = 0;   t_f[0] = 1; t_idx[0] = 5;
      t_prio[1] = 6;   t_f[1] = 1; t_idx[1] = 300;
      t_prio[2] = 301; t_f[2] = 1; t_idx[2] = 5;
      t_prio[3] = 300; t_f[3] = 1; t_idx[3] = 300;
      t_req[4] = '0;   t_prio[4] = 123; t_f[4] = 0; t_idx[4] = 0;
      t_req[5] = '1;   t_prio[5] = 77;  t_f[5] = 1; t_idx[5] = 77;
      t_req[6] = '0;   t_req[6][511] = 1'b1; t_prio[6] = 511; t_f[6] = 1; t_idx[6] = 511;
      t_req[7] = '0;   t_req[7][0] = 1'b1;   t_prio[7] = 511; t_f[7] = 1; t_idx[7] = 0;
      t_req[8] = '0;   t_req[8][510] = 1'b1; t_prio[8] = 511; t_f[8] = 1; t_idx[8] = 510;
      t_req[9] = '1;   t_prio[9] = 0;   t_f[9] = 1; t_idx[9] = 0;
      bus.out_ready = 1'b1;
      bus.rr_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.in_req = t_req[i];
         bus.in_prio = idx_t'(t_prio[i]);
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         cyc = 1;
         while (cyc < 10) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            cyc++;
         end
         n_checks++;
         if (cyc == 3) n_pass++;
         else $display("FAIL latency[%0d]: got=%0d required=3", i, cyc);
         n_checks++;
         if (bus.out_found === t_f[i] && bus.out_idx === idx_t'(t_idx[i])) n_pass++;
         else $display("FAIL directed[%0d]: idx=%0d found=%0b required idx=%0d found=%0b",
                       i, bus.out_idx, bus.out_found, t_idx[i], t_f[i]);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      req_t items[6];
      idx_t prios[6];
      int   next;
      int   guard;
      int   start;
      for (int i = 0; i < 6; i++) begin
         items[i] = gen_req();
         items[i][$urandom % N_REQ] = 1'b1;
         prios[i] = idx_t'($urandom);
      end
      start = hs_cnt;
      next = 0;
      bus.rr_mode = 1'b0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         bus.in_req = items[next];
         bus.in_prio = prios[next];
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) next++;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (next == 3 && bus.in_ready === 1'b0 && bus.out_valid === 1'b1) n_pass++;
      else $display("FAIL stall_fill: accepted=%0d in_ready=%0b out_valid=%0b required 3/0/1",
                    next, bus.in_ready, bus.out_valid);
      bus.out_ready = 1'b1;
      guard = 0;
      while (next < 6 && guard < 30) begin
         bus.in_req = items[next];
         bus.in_prio = prios[next];
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) next++;
         @(posedge clk);
         #1;
         guard++;
      end
      bus.in_valid = 1'b0;
      guard = 0;
      while (hs_cnt < start + 6 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      n_checks++;
      if (hs_cnt - start == 6 && exp_q.size() == 0) n_pass++;
      else $display("FAIL b2b_drain: outputs=%0d pending=%0d required 6/0", hs_cnt - start, exp_q.size());
   endtask

   task automatic test_random();
      int guard;
      for (int c = 0; c < 400; c++) begin
         bus.in_valid = ($urandom % 4) != 0;
         bus.out_ready = ($urandom % 3) != 0;
         bus.rr_mode = $urandom % 2;
         bus.in_req = gen_req();
         bus.in_prio = idx_t'($urandom);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      guard = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      n_checks++;
      if (exp_q.size() == 0 && bus.out_valid === 1'b0) n_pass++;
      else $display("FAIL random_drain: pending=%0d out_valid=%0b required 0/0", exp_q.size(), bus.out_valid);
   endtask

   task automatic test_round_robin();
      req_t rr_req;
      req_t seq_req[5];
      bit   seq_f[5];
      int   seq_idx[5];
      int   start;
      int   guard;
      test_reset();
      rr_req = '0;
      rr_req[10] = 1'b1;
      rr_req[20] = 1'b1;
      rr_req[511] = 1'b1;
      seq_req[0] = rr_req; seq_f[0] = 1; seq_idx[0] = 10;
      seq_req[1] = rr_req; seq_f[1] = 1; seq_idx[1] = 20;
      seq_req[2] = '0;     seq_f[2] = 0; seq_idx[2] = 0;
      seq_req[3] = rr_req; seq_f[3] = 1; seq_idx[3] = 511;
      seq_req[4] = rr_req; seq_f[4] = 1; seq_idx[4] = 10;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start = hs_cnt;
         bus.rr_mode = 1'b1;
         bus.in_prio = idx_t'($urandom);
         bus.in_req = seq_req[i];
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.rr_mode = $urandom % 2;
         guard = 0;
         while (hs_cnt == start && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
         end
         n_checks++;
         if (hs_cnt == start + 1 && last_found == seq_f[i] && last_idx == seq_idx[i]) n_pass++;
         else $display("FAIL rr_grant[%0d]: idx=%0d found=%0b outputs=%0d required idx=%0d found=%0b outputs=1",
                       i, last_idx, last_found, hs_cnt - start, seq_idx[i], seq_f[i]);
      end
   endtask

   task automatic test_reset_in_flight();
      int seen;
      int start;
      int guard;
      bus.rr_mode = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_req = '1;
      bus.in_prio = 9'd200;
      bus.in_valid = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid === 1'b1) n_pass++;
      else $display("FAIL flight_setup: out_valid=%0b required=1", bus.out_valid);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid === 1'b0) n_pass++;
      else $display("FAIL async_reset: out_valid=%0b required=0", bus.out_valid);
      exp_q.delete();
      rr_model = 0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen++;
      end
      n_checks++;
      if (seen == 0) n_pass++;
      else $display("FAIL stale_output: cycles_valid=%0d required=0", seen);
      @(posedge clk);
      #1;
      start = hs_cnt;
      bus.rr_mode = 1'b1;
      bus.in_req = '1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      guard = 0;
      while (hs_cnt == start && guard < 10) begin
         @(posedge clk);
         #1;
         guard++;
      end
      n_checks++;
      if (hs_cnt == start + 1 && last_found == 1 && last_idx == 0) n_pass++;
      else $display("FAIL rr_after_reset: idx=%0d found=%0b outputs=%0d required idx=0 found=1 outputs=1",
                    last_idx, last_found, hs_cnt - start);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_req = '0;
      bus.in_prio = '0;
      bus.rr_mode = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_round_robin();
      test_reset_in_flight();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
